// File: rtl/servo_ramp.sv
// Servo angle ramp: walks the output angle one degree per STEP_TICKS cycles
// toward a clamped target, then holds SETTLE_TICKS cycles before signalling completion.
module servo_ramp #(
  parameter int unsigned STEP_TICKS   = 500_000,
  parameter int unsigned SETTLE_TICKS = 250_000,
  parameter int unsigned MAX_ANGLE    = 180,
  parameter int unsigned HOME_ANGLE   = 90
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] target,
  input  logic       target_valid,
  input  logic       hold,
  output logic [7:0] angle,
  output logic       busy,
  output logic       at_target,
  output logic       clamped
);

  localparam int unsigned CNT_MAX = (STEP_TICKS > SETTLE_TICKS) ? STEP_TICKS : SETTLE_TICKS;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [7:0]       MAX_A       = 8'(MAX_ANGLE);
  localparam logic [7:0]       HOME_A      = 8'(HOME_ANGLE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tgt_q, tgt_d;
  logic [7:0]       angle_d;
  logic             busy_d, at_target_d, clamped_d;

  logic       load;
  logic       over_max;
  logic [7:0] tgt_clamp;
  logic [7:0] eff_tgt;
  logic [7:0] step_angle;

  // Target capture and the one-degree step toward the active target
  always_comb begin
    load      = enable & target_valid;
    over_max  = (target > MAX_A);
    tgt_clamp = over_max ? MAX_A : target;
    eff_tgt   = load ? tgt_clamp : tgt_q;
    if ((angle < eff_tgt) && (angle < MAX_A)) begin
      step_angle = angle + 8'd1;
    end else if (angle > eff_tgt) begin
      step_angle = angle - 8'd1;
    end else begin
      step_angle = angle;
    end
  end

  // Next-state and output logic; enable dominates load and hold
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    angle_d     = angle;
    tgt_d       = load ? tgt_clamp : tgt_q;
    at_target_d = 1'b0;
    clamped_d   = load & over_max;

    if (!enable) begin
      state_d = IDLE;
      tgt_d   = angle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load && (tgt_clamp != angle)) begin
            state_d = MOVING;
            cnt_d   = '0;
          end
        end
        MOVING: begin
          if (load && (tgt_clamp == angle)) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else if (!hold) begin
            if (cnt_q >= STEP_LAST) begin
              angle_d = step_angle;
              cnt_d   = '0;
              if (step_angle == eff_tgt) begin
                state_d = SETTLE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        SETTLE: begin
          if (load && (tgt_clamp != angle)) begin
            state_d = MOVING;
            cnt_d   = '0;
          end else if (!hold) begin
            if (cnt_q >= SETTLE_LAST) begin
              state_d     = IDLE;
              cnt_d       = '0;
              at_target_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d == MOVING) || (state_d == SETTLE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tgt_q     <= HOME_A;
      angle     <= HOME_A;
      busy      <= 1'b0;
      at_target <= 1'b0;
      clamped   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      angle     <= angle_d;
      busy      <= busy_d;
      at_target <= at_target_d;
      clamped   <= clamped_d;
    end
  end

endmodule

// File: tb/tb_servo_ramp.sv
// Scoreboard bench for servo_ramp: stimulus queues expected angle/clamp/done events
// with their cycle stamps; a monitor pops and compares whenever the DUT emits one.
module tb_servo_ramp;

  localparam int EV_CLAMP = 0;
  localparam int EV_ANGLE = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic       CLOCK_50;
  logic       reset_n;
  logic       enable;
  logic [7:0] target;
  logic       target_valid;
  logic       hold;
  logic [7:0] angle;
  logic       busy;
  logic       at_target;
  logic       clamped;

  int  total;
  int  bad;
  int  cyc;
  int  prev_angle;
  ev_t exp_q[$];

  servo_ramp #(
    .STEP_TICKS  (4),
    .SETTLE_TICKS(3),
    .MAX_ANGLE   (180),
    .HOME_ANGLE  (90)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .enable      (enable),
    .target      (target),
    .target_valid(target_valid),
    .hold        (hold),
    .angle       (angle),
    .busy        (busy),
    .at_target   (at_target),
    .clamped     (clamped)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input int got, input int exp);
    total = total + 1;
    if (got != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0d expected=%0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input int val);
    ev_t e;
    total = total + 1;
    if (exp_q.size() == 0) begin
      bad = bad + 1;
      $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d, expected none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        bad = bad + 1;
        $display("FAIL event: got kind=%0d val=%0d cyc=%0d, expected kind=%0d val=%0d cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: detect output events just after each rising edge
  always @(posedge CLOCK_50) begin
    cyc = cyc + 1;
    #1;
    if (!reset_n) begin
      prev_angle = int'(angle);
    end else begin
      if (clamped) check_ev(EV_CLAMP, int'(angle));
      if (int'(angle) != prev_angle) check_ev(EV_ANGLE, int'(angle));
      if (at_target) check_ev(EV_DONE, int'(angle));
      prev_angle = int'(angle);
    end
  end

  task automatic tick_to(input int c);
    while (cyc < c) @(negedge CLOCK_50);
  endtask

  // Called at a negedge; returns at the negedge following the capture edge c0
  task automatic load(input int t, output int c0);
    target       = 8'(t);
    target_valid = 1'b1;
    c0           = cyc + 1;
    @(negedge CLOCK_50);
    target_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_angle", int'(angle), 90);
    chk("rst_busy", int'(busy), 0);
    chk("rst_at_target", int'(at_target), 0);
    chk("rst_clamped", int'(clamped), 0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int c1;
    total        = 0;
    bad          = 0;
    cyc          = 0;
    prev_angle   = 90;
    reset_n      = 1'b1;
    enable       = 1'b1;
    target       = 8'd0;
    target_valid = 1'b0;
    hold         = 1'b0;
    #3;
    pulse_reset();

    // Load 93 from home: steps on edges 4, 8, 12; done 3 cycles later
    tick_to(cyc + 2);
    c0 = cyc + 1;
    push(EV_ANGLE, 91, c0 + 4);
    push(EV_ANGLE, 92, c0 + 8);
    push(EV_ANGLE, 93, c0 + 12);
    push(EV_DONE, 93, c0 + 15);
    load(93, c0);
    chk("s1_busy_start", int'(busy), 1);
    tick_to(c0 + 14);
    chk("s1_busy_settle", int'(busy), 1);
    tick_to(c0 + 15);
    chk("s1_busy_end", int'(busy), 0);
    tick_to(c0 + 18);

    // Load 200: clamp pulse, ramp 93 -> 180 and stop there
    c0 = cyc + 1;
    push(EV_CLAMP, 93, c0);
    for (int k = 1; k <= 87; k++) push(EV_ANGLE, 93 + k, c0 + 4 * k);
    push(EV_DONE, 180, c0 + 351);
    load(200, c0);
    tick_to(c0 + 370);
    chk("s2_final_angle", int'(angle), 180);
    chk("s2_busy_end", int'(busy), 0);

    // Reverse mid-move: 90 -> 95, load 88 while at 92
    pulse_reset();
    tick_to(cyc + 2);
    c0 = cyc + 1;
    push(EV_ANGLE, 91, c0 + 4);
    push(EV_ANGLE, 92, c0 + 8);
    push(EV_ANGLE, 91, c0 + 12);
    push(EV_ANGLE, 90, c0 + 16);
    push(EV_ANGLE, 89, c0 + 20);
    push(EV_ANGLE, 88, c0 + 24);
    push(EV_DONE, 88, c0 + 27);
    load(95, c0);
    tick_to(c0 + 9);
    load(88, c1);
    tick_to(c0 + 32);
    chk("s3_final_angle", int'(angle), 88);

    // Hold for 10 edges one cycle into a step period
    c0 = cyc + 1;
    push(EV_ANGLE, 89, c0 + 4);
    push(EV_ANGLE, 90, c0 + 18);
    push(EV_ANGLE, 91, c0 + 22);
    push(EV_ANGLE, 92, c0 + 26);
    push(EV_DONE, 92, c0 + 29);
    load(92, c0);
    tick_to(c0 + 5);
    hold = 1'b1;
    tick_to(c0 + 15);
    chk("s4_hold_angle", int'(angle), 89);
    chk("s4_hold_busy", int'(busy), 1);
    hold = 1'b0;
    tick_to(c0 + 34);

    // Disable at 92 during a move to 95; loads while disabled are ignored
    pulse_reset();
    tick_to(cyc + 2);
    c0 = cyc + 1;
    push(EV_ANGLE, 91, c0 + 4);
    push(EV_ANGLE, 92, c0 + 8);
    load(95, c0);
    tick_to(c0 + 9);
    enable = 1'b0;
    @(negedge CLOCK_50);
    chk("s5_busy_off", int'(busy), 0);
    chk("s5_angle_kept", int'(angle), 92);
    load(200, c1);
    tick_to(c0 + 30);
    enable = 1'b1;
    tick_to(c0 + 36);
    chk("s5_busy_reenable", int'(busy), 0);
    chk("s5_angle_reenable", int'(angle), 92);

    // Reset mid-move at 94, then load home angle: no motion
    c0 = cyc + 1;
    push(EV_ANGLE, 93, c0 + 4);
    push(EV_ANGLE, 94, c0 + 8);
    load(96, c0);
    tick_to(c0 + 9);
    chk("s6_pre_reset_angle", int'(angle), 94);
    pulse_reset();
    load(90, c1);
    tick_to(c1 + 20);
    chk("s6_busy_idle", int'(busy), 0);
    chk("s6_angle_home", int'(angle), 90);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_ramp.md
SERVO_RAMP -- requirements
Module: servo_ramp

Interface
REQ-001 Parameter STEP_TICKS, default 500_000, clock cycles per 1-degree output step (>=2).
REQ-002 Parameter SETTLE_TICKS, default 250_000, cycles held at target before completion is signalled (>=1).
REQ-003 Parameter MAX_ANGLE, default 180, upper angle limit in degrees.
REQ-004 Parameter HOME_ANGLE, default 90, angle after reset (<=MAX_ANGLE).
REQ-005 CLOCK_50  input  1  system clock; all logic on rising edge; one clock domain only.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  1 = ramping allowed; 0 = abort and hold the present angle.
REQ-008 target  input  8  requested angle in degrees; sampled only when target_valid=1.
REQ-009 target_valid  input  1  single-cycle load strobe for target.
REQ-010 hold  input  1  1 = freeze step and settle counters and angle.
REQ-011 angle  output  8  ramped angle, fed directly to the servo PWM generator.
REQ-012 busy  output  1  1 while in state MOVING or SETTLE.
REQ-013 at_target  output  1  one-cycle pulse on completion of a move.
REQ-014 clamped  output  1  one-cycle pulse when a loaded target exceeded MAX_ANGLE.

Function
REQ-015 States: IDLE, MOVING, SETTLE; 2-bit state register; unused encodings return to IDLE next cycle.
REQ-016 Internal registers: tgt[7:0] (latched target), cnt (wide enough for max(STEP_TICKS,SETTLE_TICKS)).
REQ-017 Load: on target_valid=1 and enable=1, tgt <= min(target, MAX_ANGLE); clamped=1 the following cycle iff target>MAX_ANGLE.
REQ-018 IDLE: load with clamped value != angle -> MOVING, cnt<=0; load equal to angle -> stay IDLE, no at_target pulse.
REQ-019 MOVING, hold=0: cnt increments each cycle; at the edge where cnt==STEP_TICKS-1, angle moves 1 toward tgt and cnt<=0.
REQ-020 First angle change occurs on the STEP_TICKS-th rising edge after the edge that captured target_valid.
REQ-021 MOVING: step that makes angle==tgt -> SETTLE, cnt<=0 on the same edge.
REQ-022 MOVING: new load re-latches tgt without resetting cnt; if new tgt==angle -> SETTLE, cnt<=0; direction re-evaluated every step.
REQ-023 SETTLE, hold=0: cnt increments; at cnt==SETTLE_TICKS-1 -> IDLE, at_target=1 for exactly that next cycle, busy=0.
REQ-024 SETTLE: load with tgt!=angle -> MOVING, cnt<=0, no at_target pulse; load with tgt==angle keeps SETTLE counting.
REQ-025 hold=1 in MOVING or SETTLE: cnt, angle and state frozen; loads are still accepted per REQ-017/REQ-022/REQ-024.
REQ-026 enable=0 (any state): next edge state<=IDLE, tgt<=angle, cnt<=0, busy=0, no at_target; target_valid ignored; enable has priority over load and hold.
REQ-027 Angle never leaves 0..MAX_ANGLE; step arithmetic is unsigned 8-bit with no wrap.
REQ-028 All outputs are registered; no combinational input-to-output path.

Reset
REQ-029 reset_n=0 asynchronously forces angle=HOME_ANGLE, tgt=HOME_ANGLE, state=IDLE, cnt=0, busy=0, at_target=0, clamped=0.
REQ-030 Reset asserted mid-move abandons the move; after release the block stays IDLE at HOME_ANGLE until the next load.

Verification (STEP_TICKS=4, SETTLE_TICKS=3, MAX_ANGLE=180, HOME_ANGLE=90)
REQ-031 Load 93 from reset -> angle 91,92,93 on edges 4,8,12 after capture; busy 1 through SETTLE; at_target pulses once 3 cycles after reaching 93; busy then 0.
REQ-032 Load 200 -> clamped pulses once; tgt=180; angle ramps up to 180 and stops; never exceeds 180.
REQ-033 Moving 90->95, at angle 92 load 88 -> direction reverses on the next step edge, angle ends at 88, exactly one at_target pulse.
REQ-034 hold=1 for 10 cycles mid-move -> angle and cnt unchanged; after release the next step lands on the remaining count of the interrupted period.
REQ-035 enable=0 at angle 92 during a move to 95 -> next cycle IDLE, busy 0, angle stays 92, no at_target; target_valid while enable=0 is ignored.
REQ-036 reset_n low mid-move at angle 94 -> angle=90, busy=0 immediately without a clock edge; load 90 after release -> no motion, no at_target.
